instr_fetch_unit: RTL and testbench

//  Multicycle fetch stage directly upstream of the instruction register.
//  - Owns the PC and runs a req/ack handshake with instruction memory.
//  - Buffers the returned word, then drives im_dout plus a one-cycle IRWr strobe into the instruction register.
//  - Started by the control FSM via fetch_req; PC redirected via pc_wr/pc_next.

---
 rtl/riscv_fetch_pkg.sv | 22 ++
 rtl/ifetch_timer.sv | 35 +++
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
`default_nettype none
// ============================================================================
// riscv_fetch_pkg : shared state encoding, error causes and default reset PC
// Rev 1.0
// ============================================================================
package riscv_fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } fetch_state_e;

   localparam logic [1:0]  ERR_NONE     = 2'b00;
   localparam logic [1:0]  ERR_MISALIGN = 2'b01;
   localparam logic [1:0]  ERR_TIMEOUT  = 2'b10;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/ifetch_timer.sv
`default_nettype none
// ============================================================================
// ifetch_timer : down-counter that flags expiry on the CYCLES-th run cycle
// Rev 1.0
// ============================================================================
module ifetch_timer #(
   parameter int unsigned CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic run_i,
   output logic expire_o
);

   localparam int unsigned W        = (CYCLES > 2) ? $clog2(CYCLES) : 1;
   localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= LOAD_VAL;
      end else if (run_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // Reload value is CYCLES-1, so zero is reached on the CYCLES-th run cycle.
   assign expire_o = run_i && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit : multicycle PC/fetch stage feeding the instruction register
// Optional request timeout: define IFETCH_TIMEOUT_EN.          Rev 1.0
// ============================================================================
module instr_fetch_unit
   import riscv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic        pc_wr,
   input  logic [31:0] pc_next,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_ack,
   input  logic [31:0] im_rdata,
   output logic [31:0] im_dout,
   output logic        IRWr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_busy,
   output logic        fetch_err,
   output logic [1:0]  err_cause
);

   fetch_state_e state_q;
   logic [31:0]  pc_q;
   logic [31:0]  dout_q;
   logic [31:0]  pend_pc_q;
   logic         pend_q;
   logic [1:0]   cause_q;
   logic         tmo_expire;
   logic [31:0]  idle_pc_d;

   if (TIMEOUT_CYC < 2) begin : g_timeout_range
      $error("TIMEOUT_CYC must be >= 2");
   end

`ifdef IFETCH_TIMEOUT_EN
   if (1) begin : g_timer
      ifetch_timer #(
         .CYCLES (TIMEOUT_CYC)
      ) u_timer (
         .clk      (clk),
         .rst      (rst),
         .load_i   (state_q != S_REQ),
         .run_i    (state_q == S_REQ),
         .expire_o (tmo_expire)
      );
   end
`else
   assign tmo_expire = 1'b0;
`endif

   // A redirect in the same cycle as fetch_req wins; alignment is judged on it.
   assign idle_pc_d = pc_wr ? pc_next : pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         dout_q    <= 32'h0;
         pend_q    <= 1'b0;
         pend_pc_q <= 32'h0;
         cause_q   <= ERR_NONE;
      end else begin
         case (state_q)
            S_IDLE: begin
               pc_q <= idle_pc_d;
               if (fetch_req) begin
                  if (idle_pc_d[1:0] != 2'b00) begin
                     cause_q <= ERR_MISALIGN;
                     state_q <= S_ERR;
                  end else begin
                     cause_q <= ERR_NONE;
                     state_q <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (im_ack) begin
                  dout_q  <= im_rdata;
                  state_q <= S_DONE;
               end else if (tmo_expire) begin
                  cause_q <= ERR_TIMEOUT;
                  state_q <= S_ERR;
               end
               // PC must stay stable under im_addr, so redirects wait in pend.
               if (!im_ack && tmo_expire) begin
                  pend_q <= 1'b0;
               end else if (pc_wr) begin
                  pend_q    <= 1'b1;
                  pend_pc_q <= pc_next;
               end
            end
            S_DONE: begin
               pc_q    <= pend_q ? pend_pc_q : (pc_wr ? pc_next : pc_q + 32'd4);
               pend_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign im_req     = (state_q == S_REQ);
   assign im_addr    = pc_q;
   assign im_dout    = dout_q;
   assign IRWr       = (state_q == S_DONE);
   assign pc         = pc_q;
   assign pc_plus4   = pc_q + 32'd4;
   assign fetch_busy = (state_q == S_REQ) || (state_q == S_DONE);
   assign fetch_err  = (state_q == S_ERR);
   assign err_cause  = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_unit : directed self-checking bench for instr_fetch_unit
// Rev 1.0
// ============================================================================
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req;
   logic        pc_wr;
   logic [31:0] pc_next;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ack;
   logic [31:0] im_rdata;
   logic [31:0] im_dout;
   logic        IRWr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_busy;
   logic        fetch_err;
   logic [1:0]  err_cause;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .RESET_PC    (32'h0000_0000),
      .TIMEOUT_CYC (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fetch_req  (fetch_req),
      .pc_wr      (pc_wr),
      .pc_next    (pc_next),
      .im_req     (im_req),
      .im_addr    (im_addr),
      .im_ack     (im_ack),
      .im_rdata   (im_rdata),
      .im_dout    (im_dout),
      .IRWr       (IRWr),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .fetch_busy (fetch_busy),
      .fetch_err  (fetch_err),
      .err_cause  (err_cause)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; fetch_req = 1'b0; pc_wr = 1'b0; pc_next = '0;
      im_ack = 1'b0; im_rdata = '0;
      step(); step();
      rst = 1'b0;
      chk("rst_im_req", 32'(im_req), 32'd0);
      chk("rst_irwr", 32'(IRWr), 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_dout", im_dout, 32'h0);
      chk("rst_busy", 32'(fetch_busy), 32'd0);
      chk("rst_err", 32'(fetch_err), 32'd0);
      chk("rst_cause", 32'(err_cause), 32'd0);
      chk("rst_pc4", pc_plus4, 32'h4);

      // Basic fetch, ack on the second REQ cycle
      fetch_req = 1'b1;
      step(); fetch_req = 1'b0;
      chk("f1_req", 32'(im_req), 32'd1);
      chk("f1_addr", im_addr, 32'h0);
      chk("f1_busy", 32'(fetch_busy), 32'd1);
      step();
      chk("f1_req2", 32'(im_req), 32'd1);
      im_ack = 1'b1; im_rdata = 32'h0050_0093;
      step(); im_ack = 1'b0;
      chk("f1_irwr", 32'(IRWr), 32'd1);
      chk("f1_dout", im_dout, 32'h0050_0093);
      chk("f1_pc_done", pc, 32'h0);
      step();
      chk("f1_irwr_off", 32'(IRWr), 32'd0);
      chk("f1_pc", pc, 32'h4);
      chk("f1_dout_hold", im_dout, 32'h0050_0093);

      // Redirect during REQ is deferred until DONE
      fetch_req = 1'b1;
      step(); fetch_req = 1'b0;
      pc_wr = 1'b1; pc_next = 32'h80;
      chk("rd_addr1", im_addr, 32'h4);
      step(); pc_wr = 1'b0;
      chk("rd_addr2", im_addr, 32'h4);
      chk("rd_pc_req", pc, 32'h4);
      im_ack = 1'b1; im_rdata = 32'h1111_1111;
      step(); im_ack = 1'b0;
      chk("rd_irwr", 32'(IRWr), 32'd1);
      step();
      chk("rd_pc", pc, 32'h80);

      // Misaligned redirect together with fetch_req
      pc_wr = 1'b1; pc_next = 32'h102; fetch_req = 1'b1;
      step(); pc_wr = 1'b0; fetch_req = 1'b0;
      chk("ma_req", 32'(im_req), 32'd0);
      chk("ma_err", 32'(fetch_err), 32'd1);
      chk("ma_cause", 32'(err_cause), 32'd1);
      chk("ma_pc", pc, 32'h102);
      step();
      chk("ma_err_off", 32'(fetch_err), 32'd0);
      chk("ma_cause_hold", 32'(err_cause), 32'd1);
      chk("ma_idle_req", 32'(im_req), 32'd0);

      // PC wrap at top of address space; fetch_req in DONE ignored
      pc_wr = 1'b1; pc_next = 32'hFFFF_FFFC;
      step(); pc_wr = 1'b0;
      chk("wr_pc", pc, 32'hFFFF_FFFC);
      chk("wr_pc4", pc_plus4, 32'h0);
      fetch_req = 1'b1;
      step(); fetch_req = 1'b0;
      chk("wr_cause_clr", 32'(err_cause), 32'd0);
      chk("wr_addr", im_addr, 32'hFFFF_FFFC);
      im_ack = 1'b1; im_rdata = 32'hCAFE_0013;
      step(); im_ack = 1'b0; fetch_req = 1'b1;
      chk("wr_irwr", 32'(IRWr), 32'd1);
      step(); fetch_req = 1'b0;
      chk("wr_pc0", pc, 32'h0);
      chk("wr_pc4b", pc_plus4, 32'h4);
      chk("ign_req", 32'(im_req), 32'd0);
      step();
      chk("ign_req2", 32'(im_req), 32'd0);

      // Reset in REQ followed by a late ack
      fetch_req = 1'b1;
      step(); fetch_req = 1'b0;
      chk("rr_req", 32'(im_req), 32'd1);
      rst = 1'b1;
      step(); rst = 1'b0;
      im_ack = 1'b1; im_rdata = 32'hDEAD_BEEF;
      chk("rr_req_off", 32'(im_req), 32'd0);
      chk("rr_dout", im_dout, 32'h0);
      chk("rr_pc", pc, 32'h0);
      chk("rr_busy", 32'(fetch_busy), 32'd0);
      step(); im_ack = 1'b0;
      chk("rr_irwr", 32'(IRWr), 32'd0);
      chk("rr_dout2", im_dout, 32'h0);
      chk("rr_req2", 32'(im_req), 32'd0);

`ifdef IFETCH_TIMEOUT_EN
      // No ack: request dropped after four REQ cycles
      fetch_req = 1'b1;
      step(); fetch_req = 1'b0;
      step(); step(); step();
      chk("to_req4", 32'(im_req), 32'd1);
      step();
      chk("to_req_off", 32'(im_req), 32'd0);
      chk("to_err", 32'(fetch_err), 32'd1);
      chk("to_cause", 32'(err_cause), 32'd2);
      chk("to_pc", pc, 32'h0);
      step();
      chk("to_err_off", 32'(fetch_err), 32'd0);

      // Ack on the expiring cycle wins
      fetch_req = 1'b1;
      step(); fetch_req = 1'b0;
      step(); step(); step();
      im_ack = 1'b1; im_rdata = 32'h0000_0013;
      step(); im_ack = 1'b0;
      chk("ta_irwr", 32'(IRWr), 32'd1);
      chk("ta_err", 32'(fetch_err), 32'd0);
      chk("ta_dout", im_dout, 32'h0000_0013);
      step();
      chk("ta_pc", pc, 32'h4);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
